switch_debouncer: RTL and testbench

- Conditions the raw DE1-SoC slide switches (SW[9:0]) before they reach the switches PIO input of the soc_system Qsys top (switches_0_external_connection_export).
- Provides metastability synchronisation and per-bit counter debounce on every switch.
- Also produces one-cycle rise/fall event pulses for any future interrupt or edge logic.
- Sits in the top-level wrapper, directly upstream of the soc_system instance, in the clk_clk domain.

---
 rtl/soc_io_pkg.sv | 14 +
 rtl/switch_debounce_bit.sv | 69 ++++++
 rtl/switch_debouncer.sv | 51 +++++
 tb/tb_switch_debouncer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/soc_io_pkg.sv
// Shared constants for the DE1-SoC I/O conditioning blocks that sit in front of the soc_system PIOs.
package soc_io_pkg;

    localparam int SW_WIDTH               = 10;
    localparam int LED_WIDTH              = 10;
    localparam int DEBOUNCE_20MS_AT_50MHZ = 1000000;
    localparam int DEBOUNCE_SIM           = 8;

    // Counter width able to hold values 0..cycles.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/switch_debounce_bit.sv
// One switch: synchroniser chain, stability counter, accepted level and registered rise/fall pulses.
module switch_debounce_bit
    import soc_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS_AT_50MHZ,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sw_raw_i,
    output logic sw_stable_o,
    output logic rise_o,
    output logic fall_o,
    output logic pulse_d_o
);

    localparam int                CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   sw_sync;

    assign sw_sync = sync_q[SYNC_STAGES-1];

    // Any cycle where the synchronised level matches the accepted one clears the count.
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], sw_raw_i};
        cnt_d    = '0;
        stable_d = stable_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (sw_sync != stable_q) begin
            if (cnt_q >= CNT_LAST) begin
                stable_d = sw_sync;
                rise_d   = sw_sync;
                fall_d   = ~sw_sync;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign sw_stable_o = stable_q;
    assign rise_o      = rise_q;
    assign fall_o      = fall_q;
    // Next-cycle pulse, lets the parent register an aligned event flag.
    assign pulse_d_o   = rise_d | fall_d;

endmodule

// File: rtl/switch_debouncer.sv
// Debounces the slide switches feeding the switches PIO; also emits per-bit edge pulses and a summary event.
module switch_debouncer
    import soc_io_pkg::*;
#(
    parameter int NUM_SW          = SW_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS_AT_50MHZ,
    parameter int SYNC_STAGES     = 2
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [NUM_SW-1:0] sw_raw,
    output logic [NUM_SW-1:0] sw_stable,
    output logic [NUM_SW-1:0] sw_rise,
    output logic [NUM_SW-1:0] sw_fall,
    output logic              sw_event
);

    logic [NUM_SW-1:0] pulse_d;
    logic              event_q, event_d;

    generate
        for (genvar g = 0; g < NUM_SW; g++) begin : g_bit
            switch_debounce_bit #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .SYNC_STAGES     (SYNC_STAGES)
            ) u_bit (
                .clk_i       (clk_clk),
                .rst_ni      (reset_reset_n),
                .sw_raw_i    (sw_raw[g]),
                .sw_stable_o (sw_stable[g]),
                .rise_o      (sw_rise[g]),
                .fall_o      (sw_fall[g]),
                .pulse_d_o   (pulse_d[g])
            );
        end
    endgenerate

    // Built from the bits' next-state pulses so the flag lands in the same cycle as them.
    assign event_d = |pulse_d;

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            event_q <= 1'b0;
        end else begin
            event_q <= event_d;
        end
    end

    assign sw_event = event_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: a DEBOUNCE_SIM build and a DEBOUNCE_CYCLES=1 build driven from the same pins.
module tb_switch_debouncer;
    import soc_io_pkg::*;

    localparam int N    = SW_WIDTH;
    localparam int S    = 2;
    localparam int MAXE = 4096;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] sw_raw = '0;
    logic [N-1:0] st8, rise8, fall8, st1, rise1, fall1;
    logic         ev8, ev1;

    always #10 clk = ~clk;

    switch_debouncer #(.NUM_SW(N), .DEBOUNCE_CYCLES(DEBOUNCE_SIM), .SYNC_STAGES(S)) dut8 (
        .clk_clk(clk), .reset_reset_n(rst_n), .sw_raw(sw_raw),
        .sw_stable(st8), .sw_rise(rise8), .sw_fall(fall8), .sw_event(ev8));

    switch_debouncer #(.NUM_SW(N), .DEBOUNCE_CYCLES(1), .SYNC_STAGES(S)) dut1 (
        .clk_clk(clk), .reset_reset_n(rst_n), .sw_raw(sw_raw),
        .sw_stable(st1), .sw_rise(rise1), .sw_fall(fall1), .sw_event(ev1));

    int checks = 0;
    int errors = 0;

    // Input history indexed by rising-edge number; the model reasons over windows of it.
    logic [N-1:0] raw_h [MAXE];
    bit           rst_h [MAXE];
    int           ne = 0;

    logic [N-1:0] m8_st = '0, m8_ri = '0, m8_fa = '0;
    logic [N-1:0] m1_st = '0, m1_ri = '0, m1_fa = '0;
    logic         m8_ev = 1'b0, m1_ev = 1'b0;

    typedef struct {
        logic [N-1:0] raw;
        int           hold;
        logic [N-1:0] exp8;
        logic [N-1:0] exp1;
    } vec_t;

    // Synchronised level seen after edge j: raw from S-1 edges earlier, zero if reset touched the chain.
    function automatic logic [N-1:0] sync_after(input int j);
        if (j < S - 1) return '0;
        for (int k = 0; k < S; k++) if (!rst_h[j - k]) return '0;
        return raw_h[j - S + 1];
    endfunction

    // A bit flips at edge n when, for the last d edges (all out of reset), the synchronised
    // level disagreed with the accepted level.
    task automatic model_edge(input int d, input int n, inout logic [N-1:0] st,
                              output logic [N-1:0] ri, output logic [N-1:0] fa, output logic ev);
        logic [N-1:0] sv;
        ri = '0;
        fa = '0;
        if (!rst_h[n]) begin
            st = '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                bit ok;
                ok = (n - d + 1 >= 0);
                for (int k = 0; k < d && ok; k++) begin
                    sv = sync_after(n - k - 1);
                    if (!rst_h[n - k] || sv[i] == st[i]) ok = 0;
                end
                if (ok) begin
                    if (st[i]) fa[i] = 1'b1;
                    else       ri[i] = 1'b1;
                end
            end
            st = st ^ (ri | fa);
        end
        ev = |(ri | fa);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (edge %0d)", nm, act, exp, ne);
        end
    endtask

    task automatic tick();
        if (ne >= MAXE) begin
            $display("FAIL history_overflow actual=%0d expected<%0d", ne, MAXE);
            $fatal(1);
        end
        raw_h[ne] = sw_raw;
        rst_h[ne] = rst_n;
        @(posedge clk);
        model_edge(DEBOUNCE_SIM, ne, m8_st, m8_ri, m8_fa, m8_ev);
        model_edge(1,            ne, m1_st, m1_ri, m1_fa, m1_ev);
        ne++;
        #1;
        chk("m8_stable", 32'(st8),   32'(m8_st));
        chk("m8_rise",   32'(rise8), 32'(m8_ri));
        chk("m8_fall",   32'(fall8), 32'(m8_fa));
        chk("m8_event",  32'(ev8),   32'(m8_ev));
        chk("m1_stable", 32'(st1),   32'(m1_st));
        chk("m1_rise",   32'(rise1), 32'(m1_ri));
        chk("m1_fall",   32'(fall1), 32'(m1_fa));
        chk("m1_event",  32'(ev1),   32'(m1_ev));
        chk("excl8",     32'(rise8 & fall8), 32'd0);
        chk("excl1",     32'(rise1 & fall1), 32'd0);
    endtask

    vec_t vecs [9];

    initial begin
        vecs[0] = '{10'h000, 20, 10'h000, 10'h000};
        vecs[1] = '{10'h001, 20, 10'h001, 10'h001};
        vecs[2] = '{10'h3FF, 20, 10'h3FF, 10'h3FF};
        vecs[3] = '{10'h0F0, 20, 10'h0F0, 10'h0F0};
        vecs[4] = '{10'h00F,  7, 10'h0F0, 10'h00F};
        vecs[5] = '{10'h0F0, 20, 10'h0F0, 10'h0F0};
        vecs[6] = '{10'h155, 10, 10'h155, 10'h155};
        vecs[7] = '{10'h2AA,  9, 10'h155, 10'h2AA};
        vecs[8] = '{10'h2AA,  1, 10'h2AA, 10'h2AA};

        // Reset and quiet release
        rst_n = 1'b0;
        sw_raw = '0;
        repeat (3) tick();
        chk("rst_state", 32'({st8, rise8, fall8, ev8}), 32'd0);
        rst_n = 1'b1;
        for (int c = 0; c < 50; c++) begin
            tick();
            chk("idle", 32'({st8, rise8, fall8, ev8}), 32'd0);
        end

        // Clean step on bit 0: accepted on the 10th edge
        sw_raw = 10'h001;
        repeat (9) tick();
        chk("lat_before", 32'(st8), 32'h000);
        tick();
        chk("lat_stable", 32'(st8), 32'h001);
        chk("lat_rise",   32'(rise8), 32'h001);
        chk("lat_event",  32'(ev8), 32'd1);
        tick();
        chk("lat_rise_1cyc",  32'(rise8), 32'h000);
        chk("lat_event_1cyc", 32'(ev8), 32'd0);

        // Bounce on bit 3: 5 high, 2 low, then held high
        sw_raw = 10'h009;
        repeat (5) begin tick(); chk("bounce_quiet", 32'(rise8 | fall8), 32'd0); end
        sw_raw = 10'h001;
        repeat (2) begin tick(); chk("bounce_quiet", 32'(rise8 | fall8), 32'd0); end
        sw_raw = 10'h009;
        repeat (9) begin tick(); chk("bounce_quiet", 32'(rise8 | fall8), 32'd0); end
        tick();
        chk("bounce_stable", 32'(st8), 32'h009);
        chk("bounce_rise",   32'(rise8), 32'h008);

        // All bits at once, up then down
        sw_raw = '0;
        repeat (20) tick();
        sw_raw = 10'h3FF;
        repeat (9) tick();
        chk("all_before", 32'(st8), 32'h000);
        tick();
        chk("all_stable", 32'(st8), 32'h3FF);
        chk("all_rise",   32'(rise8), 32'h3FF);
        chk("all_event",  32'(ev8), 32'd1);
        repeat (10) tick();
        sw_raw = '0;
        repeat (9) tick();
        chk("all_fall_before", 32'(fall8), 32'h000);
        tick();
        chk("all_fall",       32'(fall8), 32'h3FF);
        chk("all_fall_state", 32'(st8), 32'h000);

        // Reset mid-count discards the in-flight debounce and clears the synchroniser
        repeat (5) tick();
        sw_raw = 10'h0F0;
        repeat (7) tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_8", 32'({st8, rise8, fall8, ev8}), 32'd0);
        chk("midrst_1", 32'({st1, rise1, fall1, ev1}), 32'd0);
        rst_n = 1'b1;
        repeat (9) tick();
        chk("midrst_before", 32'(st8), 32'h000);
        tick();
        chk("midrst_stable", 32'(st8), 32'h0F0);
        chk("midrst_rise",   32'(rise8), 32'h0F0);

        // Table of holds, including ones just short of the debounce time
        foreach (vecs[v]) begin
            sw_raw = vecs[v].raw;
            repeat (vecs[v].hold) tick();
            chk($sformatf("vec%0d_st8", v), 32'(st8), 32'(vecs[v].exp8));
            chk($sformatf("vec%0d_st1", v), 32'(st1), 32'(vecs[v].exp1));
        end

        // Single-cycle build: plain synchroniser plus edge detect on bit 9
        sw_raw = 10'h0AA;
        repeat (2) tick();
        chk("d1_before", 32'(st1[9]), 32'd1);
        tick();
        chk("d1_follow", 32'(st1[9]), 32'd0);
        chk("d1_fall",   32'(fall1), 32'h200);
        sw_raw = 10'h2AA;
        tick();
        sw_raw = 10'h0AA;
        tick();
        tick();
        chk("d1_glitch_rise", 32'(rise1), 32'h200);
        tick();
        chk("d1_glitch_fall", 32'(fall1), 32'h200);
        chk("d1_glitch_st",   32'(st1), 32'h0AA);
        chk("d8_glitch_st",   32'(st8), 32'h2AA);

        // Random toggling with occasional reset, against the window model
        for (int c = 0; c < 700; c++) begin
            logic [N-1:0] flip;
            for (int b = 0; b < N; b++) flip[b] = ($urandom_range(4) == 0);
            if (c % 100 < 30) flip = '0;
            sw_raw = sw_raw ^ flip;
            rst_n  = ($urandom_range(149) != 0);
            tick();
        end
        rst_n = 1'b1;
        repeat (12) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
